trigger_capture: RTL and testbench
==================================

# trigger_capture

Trigger and acquisition stage directly upstream of the VGA waveform display. Watches the free-running ADC sample stream, arms when the display's buffer is `full`, and detects a level crossing on `trig` in the direction selected by `rising`; an auto-trigger timeout is optional. On trigger it emits exactly `NSAMPLES` decimated, screen-scaled samples on the display's `sample`/`valid` write port, then waits for the display to flip buffers before re-arming.

## Interface
- `ADC_W`, 12: ADC sample width.
- `NSAMPLES`, 640: samples per capture; matches the display's buffer depth.
- `SHIFT`, 4: right shift applied to the ADC code before screen mapping.
- `ROW_BASE`, 278: screen row of ADC code 0; output row = `ROW_BASE - (adc >> SHIFT)`.
- `AUTO_CYCLES`, 2_000_000: `clk` cycles in ARM before a forced auto trigger.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `adc_data`  in  ADC_W  unsigned ADC code.
- `adc_valid`  in  1  one-cycle strobe qualifying `adc_data`.
- `trig`  in  ADC_W  trigger level (ADC code units).
- `rising`  in  1  1 = rising-edge trigger; 0 = falling-edge trigger.
- `auto_en`  in  1  enables the auto-trigger timeout.
- `decim`  in  8  keep one ADC sample in every `decim+1`.
- `full`  in  1  from display; 1 = previous capture complete and buffers swapped.
- `sample`  out  9  screen row of the captured sample.
- `valid`  out  1  one-cycle write strobe for `sample`.
- `armed`  out  1  high while in ARM.
- `auto_fired`  out  1  1 = the last capture was started by timeout; 0 = started by a real crossing.

## Operation
- States: WAIT_READY, ARM, CAPTURE.
- **WAIT_READY**
  - Leave when `full`==1; go to ARM.
  - On entry to ARM, latch `trig`, `rising`, `decim` and `auto_en`. The latched copies are used until the next ARM entry.
  - Clear `prev_ok` and the timeout counter.
- **ARM** (`armed`=1)
  - On each `adc_valid`: store `prev`=`adc_data` and set `prev_ok`.
  - Rising trigger: `prev_ok && prev < trig_l && adc_data >= trig_l`.
  - Falling trigger: `prev_ok && prev > trig_l && adc_data <= trig_l`.
  - Comparisons are unsigned, full ADC_W.
  - On trigger: the triggering `adc_data` is output sample 0. Go to CAPTURE with `auto_fired`=0.
  - The timeout counter increments every cycle in ARM.
  - When the counter reaches `AUTO_CYCLES-1` with `auto_en_l`=1, the next `adc_valid` is forced as sample 0 with `auto_fired`=1.
  - A crossing on that same strobe takes priority: `auto_fired`=0.
- **CAPTURE**
  - Decimation counter `dc` is reset to 0 when sample 0 is emitted.
  - On each `adc_valid`: if `dc`==`decim_l`, emit a sample and set `dc`=0; otherwise increment `dc`.
  - `decim_l`=0 emits every strobe.
  - Sample counter `n` counts emitted samples, 0..NSAMPLES-1. After sample NSAMPLES-1, go to WAIT_READY.
- **Scaling:** `s = adc_data >> SHIFT`; `sample = ROW_BASE - s`, computed in 10 bits. Results that would be negative saturate to 0.
- **Ready handshake:** `full` is only sampled in WAIT_READY.
  - The display deasserts `full` on the first write; this is ignored during CAPTURE.
  - If `full` is still 1 when returning to WAIT_READY (buffer swapped on the last write), ARM is entered on the next cycle.
- **Reset**
  - Takes effect on the next edge from any state, including mid-CAPTURE. A partial capture is abandoned; no further `valid` pulses are issued.
  - Reset values: state=WAIT_READY, `valid`=0, `sample`=0, `armed`=0, `auto_fired`=0, all counters 0, `prev_ok`=0.

## Timing
- `valid`/`sample` are registered. Latency is exactly 1 cycle from the qualifying `adc_valid` edge.
- `valid` is high for exactly one cycle per emitted sample. `sample` holds its value until the next emission.
- Exactly NSAMPLES `valid` pulses per capture; never more than one per `adc_valid`.
- WAIT_READY→ARM: 1 cycle after `full` is seen high.
- ARM→CAPTURE: the same edge that issues the sample 0 `valid`.
- Back-to-back `adc_valid` (every cycle) is supported at full rate.
- `armed` reflects the registered state: it rises the cycle after `full` is sampled and falls with the sample 0 `valid`.
- `auto_fired` updates on the same edge as the sample 0 `valid`.

## Test plan
- **Reset state:** reset, `full`=0 → stays in WAIT_READY, no `valid`, all outputs 0.
- **Rising trigger:** `full`=1, `rising`=1, `trig`=2048, ramp 0..4095 step 16 every cycle.
  - First `valid` carries `adc_data`=2048 → `sample`=278-128=150.
  - Exactly 640 `valid` pulses follow, `auto_fired`=0.
- **Falling trigger with decimation:** `rising`=0, `trig`=1000, `decim`=3, descending ramp.
  - Trigger on the first sample ≤1000 with previous >1000.
  - Subsequent `valid` pulses occur on every 4th `adc_valid`; 640 total.
- **Auto trigger:** `AUTO_CYCLES`=100, `auto_en`=1, constant `adc_data`=0.
  - Capture starts on the first `adc_valid` at/after cycle 99 of ARM; `auto_fired`=1; `sample`=278.
  - Same stimulus with `auto_en`=0 → never leaves ARM.
- **Re-arm handshake:** hold `full`=0 after a capture → no ARM and no `valid`. Raise `full` → `armed`=1 the next cycle.
- **Reset mid-capture:** reset after 300 samples → `valid` stops immediately. After release with `full`=1, a fresh 640-sample capture follows a new trigger.

Source files
------------

// File: rtl/trigger_capture_if.sv
// Display write port shared between trigger_capture and the waveform display.
//   full   : display -> capture, previous capture complete and buffers swapped
//   sample : capture -> display, screen row of the captured sample
//   valid  : capture -> display, one-cycle write strobe for sample
interface trigger_capture_if;
  logic       full;
  logic [8:0] sample;
  logic       valid;

  modport master (input full, output sample, output valid);
  modport slave  (output full, input sample, input valid);
endinterface

// File: rtl/trigger_capture.sv
// Trigger and acquisition stage feeding the VGA waveform display.
// Arms once the display reports `full`, waits for a level crossing of the
// latched trigger level (or an optional auto-trigger timeout), then writes
// NSAMPLES decimated, screen-scaled samples to the display port.
//
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   adc_data    : unsigned ADC code, qualified by adc_valid
//   adc_valid   : one-cycle sample strobe
//   trig        : trigger level (ADC code units)
//   rising      : 1 = rising-edge trigger, 0 = falling-edge
//   auto_en     : enable the auto-trigger timeout
//   decim       : keep one sample in every decim+1
//   disp        : display write port (full in, sample/valid out)
//   armed       : high while waiting for a trigger
//   auto_fired  : last capture was started by the timeout
module trigger_capture #(
  parameter int ADC_W       = 12,
  parameter int NSAMPLES    = 640,
  parameter int SHIFT       = 4,
  parameter int ROW_BASE    = 278,
  parameter int AUTO_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   trig,
  input  logic               rising,
  input  logic               auto_en,
  input  logic [7:0]         decim,
  trigger_capture_if.master  disp,
  output logic               armed,
  output logic               auto_fired
);

  localparam int TW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int NW = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;

  typedef enum logic [1:0] {WAIT_READY, ARM, CAPTURE} state_t;

  // Trigger settings captured on ARM entry; held for the whole capture.
  typedef struct packed {
    logic [ADC_W-1:0] trig;
    logic             rising;
    logic [7:0]       decim;
    logic             auto_en;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [ADC_W-1:0] prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [7:0]       dc_q, dc_d;
  logic [NW-1:0]    n_q, n_d;
  logic [8:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             auto_fired_q, auto_fired_d;

  logic crossing, timeout_hit, auto_hit;

  // Row = ROW_BASE - (code >> SHIFT), clamped at the top of the screen.
  function automatic logic [8:0] scale(input logic [ADC_W-1:0] d);
    logic [31:0] s;
    s = 32'(d >> SHIFT);
    if (s > 32'(ROW_BASE)) return 9'd0;
    return 9'(32'(ROW_BASE) - s);
  endfunction

  always_comb begin
    if (cfg_q.rising)
      crossing = prev_ok_q && (prev_q < cfg_q.trig) && (adc_data >= cfg_q.trig);
    else
      crossing = prev_ok_q && (prev_q > cfg_q.trig) && (adc_data <= cfg_q.trig);
  end

  // Counter saturates at AUTO_CYCLES-1, so the timeout stays pending until
  // the next strobe arrives.
  assign timeout_hit = (tcnt_q == TW'(AUTO_CYCLES - 1));
  assign auto_hit    = cfg_q.auto_en && timeout_hit;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    tcnt_d       = tcnt_q;
    dc_d         = dc_q;
    n_d          = n_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    auto_fired_d = auto_fired_q;

    case (state_q)
      WAIT_READY: begin
        if (disp.full) begin
          state_d   = ARM;
          cfg_d     = '{trig: trig, rising: rising, decim: decim, auto_en: auto_en};
          prev_ok_d = 1'b0;
          tcnt_d    = '0;
        end
      end

      ARM: begin
        if (!timeout_hit) tcnt_d = tcnt_q + 1'b1;
        if (adc_valid) begin
          prev_d    = adc_data;
          prev_ok_d = 1'b1;
          if (crossing || auto_hit) begin
            // A real crossing wins over a simultaneous timeout.
            sample_d     = scale(adc_data);
            valid_d      = 1'b1;
            auto_fired_d = !crossing;
            dc_d         = '0;
            n_d          = '0;
            state_d      = (NSAMPLES == 1) ? WAIT_READY : CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (adc_valid) begin
          if (dc_q == cfg_q.decim) begin
            sample_d = scale(adc_data);
            valid_d  = 1'b1;
            dc_d     = '0;
            n_d      = n_q + 1'b1;
            // n_q is the index of the last emitted sample.
            if (n_q == NW'(NSAMPLES - 2)) state_d = WAIT_READY;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end

      default: state_d = WAIT_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_READY;
      cfg_q        <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      tcnt_q       <= '0;
      dc_q         <= '0;
      n_q          <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      auto_fired_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      tcnt_q       <= tcnt_d;
      dc_q         <= dc_d;
      n_q          <= n_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      auto_fired_q <= auto_fired_d;
    end
  end

  assign disp.sample = sample_q;
  assign disp.valid  = valid_q;
  assign armed       = (state_q == ARM);
  assign auto_fired  = auto_fired_q;

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig;
  logic        rising;
  logic        auto_en;
  logic [7:0]  decim;
  logic        armed;
  logic        auto_fired;

  trigger_capture_if dif();

  trigger_capture #(
    .ADC_W(12), .NSAMPLES(640), .SHIFT(4), .ROW_BASE(278), .AUTO_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig(trig), .rising(rising), .auto_en(auto_en), .decim(decim),
    .disp(dif.master), .armed(armed), .auto_fired(auto_fired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Every emitted sample, captured on the falling edge.
  int smp_q[$];
  always @(negedge clk) if (dif.valid) smp_q.push_back(int'(dif.sample));

  typedef struct {
    logic [11:0] adc;
    int          exp_row;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising trigger at 2048 on a 0..4095 step-16 ramp, one strobe per cycle.
  task automatic rising_capture(input string tag);
    int base, bad;
    rising = 1'b1; trig = 12'd2048; decim = 8'd0; auto_en = 1'b0;
    adc_valid = 1'b0; dif.full = 1'b1;
    tick();
    chk({tag, "_armed"}, int'(armed), 1);
    dif.full = 1'b0;
    base = smp_q.size();
    for (int k = 0; k < 128 + 660; k++) begin
      adc_data = 12'(16 * k); adc_valid = 1'b1;
      tick();
      if (k == 127) chk({tag, "_no_early_valid"}, int'(dif.valid), 0);
      if (k == 128) begin
        chk({tag, "_first_valid"}, int'(dif.valid), 1);
        chk({tag, "_first_sample"}, int'(dif.sample), 150);
        chk({tag, "_auto_fired"}, int'(auto_fired), 0);
        chk({tag, "_armed_fall"}, int'(armed), 0);
      end
    end
    adc_valid = 1'b0;
    tick(); tick();
    chk({tag, "_count"}, smp_q.size() - base, 640);
    bad = 0;
    for (int j = 0; j < 640 && base + j < smp_q.size(); j++)
      if (smp_q[base + j] != 278 - ((128 + j) % 256)) bad++;
    chk({tag, "_sample_errs"}, bad, 0);
  endtask

  initial begin
    vec_t vecs[10];
    int base, bad, cnt, acnt, n, c;

    vecs[0] = '{12'd0,    278};
    vecs[1] = '{12'd15,   278};
    vecs[2] = '{12'd16,   277};
    vecs[3] = '{12'd17,   277};
    vecs[4] = '{12'd100,  272};
    vecs[5] = '{12'd1000, 216};
    vecs[6] = '{12'd2048, 150};
    vecs[7] = '{12'd4079, 24};
    vecs[8] = '{12'd4080, 23};
    vecs[9] = '{12'd4095, 23};

    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; trig = '0; rising = 1'b0;
    auto_en = 1'b0; decim = '0; dif.full = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("reset_valid", int'(dif.valid), 0);
    chk("reset_sample", int'(dif.sample), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_auto_fired", int'(auto_fired), 0);
    chk("reset_no_samples", smp_q.size(), 0);

    rising_capture("rise");

    // Display not ready: no ARM, no writes.
    cnt = 0; acnt = 0;
    for (int k = 0; k < 50; k++) begin
      adc_data = 12'(37 * k); adc_valid = 1'b1;
      tick();
      if (dif.valid) cnt++;
      if (armed) acnt++;
    end
    adc_valid = 1'b0;
    chk("hold_no_valid", cnt, 0);
    chk("hold_no_arm", acnt, 0);

    // Falling trigger at 1000, decim 3, strobes every other cycle.
    rising = 1'b0; trig = 12'd1000; decim = 8'd3; auto_en = 1'b0; dif.full = 1'b1;
    tick();
    chk("fall_armed_next", int'(armed), 1);
    // Live inputs change; the latched copies must stay in effect.
    rising = 1'b1; trig = 12'd0; decim = 8'd0; dif.full = 1'b0;
    base = smp_q.size();
    for (int s = 0; s < 194 + 2560 + 20; s++) begin
      adc_data = 12'(4095 - 16 * s); adc_valid = 1'b1;
      tick();
      if (s == 194) begin
        chk("fall_first_valid", int'(dif.valid), 1);
        chk("fall_first_sample", int'(dif.sample), 217);
      end
      adc_valid = 1'b0;
      tick();
      if (s == 194) chk("fall_valid_one_cycle", int'(dif.valid), 0);
    end
    tick();
    chk("fall_count", smp_q.size() - base, 640);
    bad = 0;
    for (int j = 0; j < 640 && base + j < smp_q.size(); j++)
      if (smp_q[base + j] != 23 + ((194 + 4 * j) % 256)) bad++;
    chk("fall_sample_errs", bad, 0);

    // Auto trigger with constant zero input.
    rising = 1'b1; trig = 12'd2048; decim = 8'd0; auto_en = 1'b1;
    adc_data = 12'd0; adc_valid = 1'b0; dif.full = 1'b1;
    tick();
    dif.full = 1'b0;
    cnt = 0;
    for (c = 0; c < 101 + 650; c++) begin
      adc_valid = (c == 98) || (c >= 101);
      tick();
      if (dif.valid) cnt++;
      if (c == 98) begin
        chk("auto_not_early", int'(dif.valid), 0);
        chk("auto_still_armed", int'(armed), 1);
      end
      if (c == 101) begin
        chk("auto_valid", int'(dif.valid), 1);
        chk("auto_sample", int'(dif.sample), 278);
        chk("auto_fired_set", int'(auto_fired), 1);
      end
    end
    adc_valid = 1'b0;
    chk("auto_count", cnt, 640);

    // Same stimulus with auto disabled never leaves ARM.
    auto_en = 1'b0; dif.full = 1'b1;
    tick();
    dif.full = 1'b0;
    cnt = 0; acnt = 0;
    for (int k = 0; k < 300; k++) begin
      adc_valid = 1'b1;
      tick();
      if (dif.valid) cnt++;
      if (armed) acnt++;
    end
    adc_valid = 1'b0;
    chk("noauto_no_valid", cnt, 0);
    chk("noauto_armed", acnt, 300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_from_arm", int'(armed), 0);

    // Crossing coinciding with a pending timeout is reported as real, and
    // its capture is then cut short by reset.
    rising = 1'b1; trig = 12'd2048; auto_en = 1'b1; decim = 8'd0; dif.full = 1'b1;
    tick();
    dif.full = 1'b0;
    n = 0; c = 0;
    while (n < 300 && c < 1000) begin
      adc_valid = (c == 50) || (c >= 120);
      adc_data  = (c >= 120) ? 12'd3000 : 12'd0;
      tick();
      if (dif.valid) n++;
      if (c == 120) begin
        chk("prio_valid", int'(dif.valid), 1);
        chk("prio_auto_fired", int'(auto_fired), 0);
        chk("prio_sample", int'(dif.sample), 91);
      end
      c++;
    end
    chk("mid_reached_300", n, 300);
    reset = 1'b1;
    tick();
    chk("mid_reset_valid", int'(dif.valid), 0);
    chk("mid_reset_sample", int'(dif.sample), 0);
    cnt = 0;
    tick();
    if (dif.valid) cnt++;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dif.valid) cnt++;
    end
    adc_valid = 1'b0;
    chk("mid_reset_no_valid", cnt, 0);

    // Scaling table: a real crossing, then one table entry per strobe.
    rising = 1'b1; trig = 12'd2048; decim = 8'd0; auto_en = 1'b0; dif.full = 1'b1;
    tick();
    dif.full = 1'b0;
    adc_data = 12'd0; adc_valid = 1'b1;
    tick();
    adc_data = 12'd4000;
    tick();
    chk("tbl_trigger", int'(dif.valid), 1);
    for (int i = 0; i < 10; i++) begin
      adc_data = vecs[i].adc;
      tick();
      chk("tbl_valid", int'(dif.valid), 1);
      chk($sformatf("tbl_row_%0d", vecs[i].adc), int'(dif.sample), vecs[i].exp_row);
    end
    for (int k = 0; k < 640; k++) tick();
    adc_valid = 1'b0;
    tick();

    rising_capture("rearm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
